// File: rtl/stopwatch_controller.sv
// Stopwatch control: command decode, tick prescaler, up/down count, expiry and lap freeze (LAP_HOLD_EN).
// Latency: an accepted command or a count tick shows on the registered outputs one clk edge later.
// Backpressure: none. Buttons are levels; overlapping or held buttons are ignored until a lone fresh press.
module stopwatch_controller #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             lap,
    input  logic             countDown,
    input  logic [WIDTH-1:0] loadValue,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] display,
    output logic             running,
    output logic             up,
    output logic             lapActive,
    output logic             done
);

    // Prescaler width never drops to zero, even for PRESCALE=1.
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

`ifdef LAP_HOLD_EN
    typedef enum logic [1:0] {
        ST_STOPPED  = 2'd0,
        ST_COUNTING = 2'd1,
        ST_EXPIRED  = 2'd2,
        ST_LAPPED   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_STOPPED  = 2'd0,
        ST_COUNTING = 2'd1,
        ST_EXPIRED  = 2'd2
    } state_t;
`endif

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   presc;
    logic [PW-1:0]   presc_nxt;
    logic [3:0]      btn;
    logic [3:0]      btn_prev;
    logic            accept;
    logic            cmd_start;
    logic            cmd_stop;
    logic            cmd_clear;
    logic            run_state;
    logic            tick;
    logic            expiring;
    logic [WIDTH-1:0] count_nxt;
    logic [WIDTH-1:0] display_nxt;
    logic [WIDTH-1:0] reload_val;
    logic            up_nxt;
    logic            done_nxt;
    logic            running_nxt;
    logic            lapact_nxt;
`ifdef LAP_HOLD_EN
    logic            cmd_lap;
    logic            lap_capture;
`endif

    // Button vector ordered {start, stop, clear, lap}; lap always takes part in exclusivity.
    assign btn = {start, stop, clear, lap};

    // A command needs exactly one button high and that button newly pressed this edge.
    assign accept    = $onehot(btn) && (|(btn & ~btn_prev));
    assign cmd_start = accept && btn[3];
    assign cmd_stop  = accept && btn[2];
    assign cmd_clear = accept && btn[1];
`ifdef LAP_HOLD_EN
    assign cmd_lap   = accept && btn[0];
`endif

    // Counting continues in both the plain and the lapped running states.
`ifdef LAP_HOLD_EN
    assign run_state = (state == ST_COUNTING) || (state == ST_LAPPED);
`else
    assign run_state = (state == ST_COUNTING);
`endif

    assign tick       = run_state && (presc == PRESC_LAST);
    assign reload_val = countDown ? loadValue : '0;

    // Next-state and next-output logic; the tick is resolved before any command overrides the state.
    always_comb begin
        state_nxt   = state;
        count_nxt   = count;
        presc_nxt   = presc;
        up_nxt      = up;
        done_nxt    = 1'b0;
        expiring    = 1'b0;
`ifdef LAP_HOLD_EN
        lap_capture = 1'b0;
`endif

        // Prescaler free-runs only while counting; it holds in stopped and expired states.
        if (run_state) begin
            presc_nxt = tick ? '0 : presc + PW'(1);
        end

        // Count step. Counting down into zero (or ticking while already zero) expires.
        if (tick) begin
            if (up) begin
                count_nxt = count + WIDTH'(1);
            end else if (count <= WIDTH'(1)) begin
                count_nxt = '0;
                state_nxt = ST_EXPIRED;
                done_nxt  = 1'b1;
                expiring  = 1'b1;
            end else begin
                count_nxt = count - WIDTH'(1);
            end
        end

        case (state)
            ST_STOPPED: begin
                if (cmd_start) begin
                    state_nxt = ST_COUNTING;
                    up_nxt    = ~countDown;
                    presc_nxt = '0;
                end else if (cmd_clear) begin
                    count_nxt = reload_val;
                end
            end
            ST_COUNTING: begin
                if (cmd_stop) begin
                    state_nxt = ST_STOPPED;
`ifdef LAP_HOLD_EN
                end else if (cmd_lap && !expiring) begin
                    state_nxt   = ST_LAPPED;
                    lap_capture = 1'b1;
`endif
                end
            end
`ifdef LAP_HOLD_EN
            ST_LAPPED: begin
                if (cmd_stop) begin
                    state_nxt = ST_STOPPED;
                end else if (cmd_lap && !expiring) begin
                    lap_capture = 1'b1;
                end
            end
`endif
            ST_EXPIRED: begin
                if (cmd_clear) begin
                    count_nxt = reload_val;
                    state_nxt = ST_STOPPED;
                end else if (cmd_stop) begin
                    state_nxt = ST_STOPPED;
                end
            end
            default: begin
                state_nxt = ST_STOPPED;
            end
        endcase
    end

    // Display and status decode from the next state so every output is a plain register.
    // In the lapped state the display register itself holds the frozen split value.
    always_comb begin
        display_nxt = count_nxt;
        running_nxt = 1'b0;
        lapact_nxt  = 1'b0;
`ifdef LAP_HOLD_EN
        if (state_nxt == ST_LAPPED) begin
            display_nxt = lap_capture ? count : display;
        end
        running_nxt = (state_nxt == ST_COUNTING) || (state_nxt == ST_LAPPED);
        lapact_nxt  = (state_nxt == ST_LAPPED);
`else
        running_nxt = (state_nxt == ST_COUNTING);
`endif
    end

    // State, count and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state     <= ST_STOPPED;
            count     <= '0;
            display   <= '0;
            presc     <= '0;
            btn_prev  <= '0;
            running   <= 1'b0;
            up        <= 1'b1;
            lapActive <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            count     <= count_nxt;
            display   <= display_nxt;
            presc     <= presc_nxt;
            btn_prev  <= btn;
            running   <= running_nxt;
            up        <= up_nxt;
            lapActive <= lapact_nxt;
            done      <= done_nxt;
        end
    end

endmodule

// File: tb/tb_stopwatch_controller.sv
// Bench for stopwatch_controller (WIDTH=8, PRESCALE=4); covers both builds of LAP_HOLD_EN.
// Each scenario drives a step table; expected outputs are queued at drive time and popped after the wait.
// No handshake on the DUT; waits are fixed cycle counts and a watchdog bounds the run.
module tb_stopwatch_controller;

    localparam int WIDTH    = 8;
    localparam int PRESCALE = 4;
`ifdef LAP_HOLD_EN
    localparam bit LAPEN = 1'b1;
`else
    localparam bit LAPEN = 1'b0;
`endif

    localparam logic [3:0] B_NONE  = 4'b0000;
    localparam logic [3:0] B_START = 4'b1000;
    localparam logic [3:0] B_STOP  = 4'b0100;
    localparam logic [3:0] B_CLEAR = 4'b0010;
    localparam logic [3:0] B_LAP   = 4'b0001;

    logic             clk = 1'b0;
    logic             resetN;
    logic             start;
    logic             stop;
    logic             clear;
    logic             lap;
    logic             countDown;
    logic [WIDTH-1:0] loadValue;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] display;
    logic             running;
    logic             up;
    logic             lapActive;
    logic             done;

    typedef struct packed {
        logic [7:0] count;
        logic [7:0] display;
        logic       running;
        logic       up;
        logic       lapact;
        logic       done;
    } obs_t;

    typedef struct {
        logic       rn;
        logic [3:0] b;
        logic       cd;
        logic [7:0] lv;
        int         n;
        obs_t       e;
        string      name;
    } step_t;

    obs_t  sb_q[$];
    string sbn_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    always #5 clk = ~clk;

    stopwatch_controller #(.WIDTH(WIDTH), .PRESCALE(PRESCALE)) dut (
        .clk       (clk),
        .resetN    (resetN),
        .start     (start),
        .stop      (stop),
        .clear     (clear),
        .lap       (lap),
        .countDown (countDown),
        .loadValue (loadValue),
        .count     (count),
        .display   (display),
        .running   (running),
        .up        (up),
        .lapActive (lapActive),
        .done      (done)
    );

    function automatic step_t mk(input logic rn, input logic [3:0] b, input logic cd,
                                 input logic [7:0] lv, input int n,
                                 input logic [7:0] c, input logic [7:0] d,
                                 input logic r, input logic u, input logic l,
                                 input logic dn, input string name);
        step_t s;
        s.rn = rn; s.b = b; s.cd = cd; s.lv = lv; s.n = n; s.name = name;
        s.e.count = c; s.e.display = d; s.e.running = r;
        s.e.up = u; s.e.lapact = l; s.e.done = dn;
        return s;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.count = count; o.display = display; o.running = running;
        o.up = up; o.lapact = lapActive; o.done = done;
        return o;
    endfunction

    task automatic drive(input step_t s);
        resetN = s.rn;
        {start, stop, clear, lap} = s.b;
        countDown = s.cd;
        loadValue = s.lv;
        sb_q.push_back(s.e);
        sbn_q.push_back(s.name);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step_t st[$];
        obs_t  got, exp;
        string nm;
        st.push_back(mk(0, B_NONE, 0, 0, 2, 0, 0, 0, 1, 0, 0, "reset_hold"));
        st.push_back(mk(1, B_NONE, 0, 0, 3, 0, 0, 0, 1, 0, 0, "reset_release_idle"));
        foreach (st[i]) begin
            drive(st[i]);
            wait_cyc(st[i].n);
            exp = sb_q.pop_front(); nm = sbn_q.pop_front(); got = observe();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s: got cnt=%0d disp=%0d run=%b up=%b lap=%b done=%b, expected cnt=%0d disp=%0d run=%b up=%b lap=%b done=%b",
                         nm, got.count, got.display, got.running, got.up, got.lapact, got.done,
                         exp.count, exp.display, exp.running, exp.up, exp.lapact, exp.done);
            end
        end
    endtask

    task automatic test_count_up();
        step_t st[$];
        obs_t  got, exp;
        string nm;
        st.push_back(mk(1, B_START, 0, 0, 1,  0, 0, 1, 1, 0, 0, "start_accept"));
        st.push_back(mk(1, B_NONE,  0, 0, 3,  0, 0, 1, 1, 0, 0, "before_first_tick"));
        st.push_back(mk(1, B_NONE,  0, 0, 1,  1, 1, 1, 1, 0, 0, "first_tick"));
        st.push_back(mk(1, B_NONE,  0, 0, 16, 5, 5, 1, 1, 0, 0, "count_5_after_20"));
        st.push_back(mk(1, B_NONE,  0, 0, 3,  5, 5, 1, 1, 0, 0, "pre_stop"));
        st.push_back(mk(1, B_STOP,  0, 0, 1,  6, 6, 0, 1, 0, 0, "stop_with_tick"));
        st.push_back(mk(1, B_NONE,  0, 0, 5,  6, 6, 0, 1, 0, 0, "stopped_hold"));
        foreach (st[i]) begin
            drive(st[i]);
            wait_cyc(st[i].n);
            exp = sb_q.pop_front(); nm = sbn_q.pop_front(); got = observe();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s: got cnt=%0d disp=%0d run=%b up=%b lap=%b done=%b, expected cnt=%0d disp=%0d run=%b up=%b lap=%b done=%b",
                         nm, got.count, got.display, got.running, got.up, got.lapact, got.done,
                         exp.count, exp.display, exp.running, exp.up, exp.lapact, exp.done);
            end
        end
    endtask

    task automatic test_countdown();
        step_t st[$];
        obs_t  got, exp;
        string nm;
        st.push_back(mk(1, B_CLEAR, 1, 3, 1, 3, 3, 0, 1, 0, 0, "clear_load"));
        st.push_back(mk(1, B_NONE,  1, 3, 1, 3, 3, 0, 1, 0, 0, "clear_release"));
        st.push_back(mk(1, B_START, 1, 3, 1, 3, 3, 1, 0, 0, 0, "start_down"));
        st.push_back(mk(1, B_NONE,  0, 3, 3, 3, 3, 1, 0, 0, 0, "down_wait_dir_toggled"));
        st.push_back(mk(1, B_NONE,  0, 3, 1, 2, 2, 1, 0, 0, 0, "down_2"));
        st.push_back(mk(1, B_NONE,  0, 3, 4, 1, 1, 1, 0, 0, 0, "down_1"));
        st.push_back(mk(1, B_NONE,  0, 3, 3, 1, 1, 1, 0, 0, 0, "down_pre_expire"));
        st.push_back(mk(1, B_NONE,  0, 3, 1, 0, 0, 0, 0, 0, 1, "expire_done"));
        st.push_back(mk(1, B_NONE,  1, 3, 1, 0, 0, 0, 0, 0, 0, "done_one_cycle"));
        st.push_back(mk(1, B_START, 1, 3, 1, 0, 0, 0, 0, 0, 0, "expired_start_ignored"));
        st.push_back(mk(1, B_NONE,  1, 3, 2, 0, 0, 0, 0, 0, 0, "expired_hold"));
        st.push_back(mk(1, B_CLEAR, 1, 3, 1, 3, 3, 0, 0, 0, 0, "expired_clear"));
        st.push_back(mk(1, B_NONE,  1, 3, 1, 3, 3, 0, 0, 0, 0, "after_clear"));
        st.push_back(mk(1, B_CLEAR, 1, 0, 1, 0, 0, 0, 0, 0, 0, "clear_zero"));
        st.push_back(mk(1, B_NONE,  1, 0, 1, 0, 0, 0, 0, 0, 0, "clear_zero_rel"));
        st.push_back(mk(1, B_START, 1, 0, 1, 0, 0, 1, 0, 0, 0, "start_at_zero"));
        st.push_back(mk(1, B_NONE,  1, 0, 3, 0, 0, 1, 0, 0, 0, "zero_wait"));
        st.push_back(mk(1, B_NONE,  1, 0, 1, 0, 0, 0, 0, 0, 1, "zero_expire"));
        st.push_back(mk(1, B_NONE,  1, 0, 1, 0, 0, 0, 0, 0, 0, "zero_done_drop"));
        foreach (st[i]) begin
            drive(st[i]);
            wait_cyc(st[i].n);
            exp = sb_q.pop_front(); nm = sbn_q.pop_front(); got = observe();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s: got cnt=%0d disp=%0d run=%b up=%b lap=%b done=%b, expected cnt=%0d disp=%0d run=%b up=%b lap=%b done=%b",
                         nm, got.count, got.display, got.running, got.up, got.lapact, got.done,
                         exp.count, exp.display, exp.running, exp.up, exp.lapact, exp.done);
            end
        end
    endtask

    task automatic test_wrap();
        step_t st[$];
        obs_t  got, exp;
        string nm;
        st.push_back(mk(1, B_CLEAR, 1, 254, 1, 254, 254, 0, 0, 0, 0, "load_254"));
        st.push_back(mk(1, B_NONE,  0, 254, 1, 254, 254, 0, 0, 0, 0, "load_rel"));
        st.push_back(mk(1, B_START, 0, 254, 1, 254, 254, 1, 1, 0, 0, "start_up"));
        st.push_back(mk(1, B_NONE,  0, 254, 4, 255, 255, 1, 1, 0, 0, "up_255"));
        st.push_back(mk(1, B_NONE,  0, 254, 4, 0,   0,   1, 1, 0, 0, "wrap_0"));
        st.push_back(mk(1, B_NONE,  0, 254, 4, 1,   1,   1, 1, 0, 0, "after_wrap"));
        st.push_back(mk(1, B_STOP,  0, 254, 1, 1,   1,   0, 1, 0, 0, "stop_wrap"));
        st.push_back(mk(1, B_NONE,  0, 254, 1, 1,   1,   0, 1, 0, 0, "stop_rel"));
        foreach (st[i]) begin
            drive(st[i]);
            wait_cyc(st[i].n);
            exp = sb_q.pop_front(); nm = sbn_q.pop_front(); got = observe();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s: got cnt=%0d disp=%0d run=%b up=%b lap=%b done=%b, expected cnt=%0d disp=%0d run=%b up=%b lap=%b done=%b",
                         nm, got.count, got.display, got.running, got.up, got.lapact, got.done,
                         exp.count, exp.display, exp.running, exp.up, exp.lapact, exp.done);
            end
        end
    endtask

    task automatic test_mashing();
        step_t st[$];
        obs_t  got, exp;
        string nm;
        st.push_back(mk(1, B_START, 0, 0, 1, 1, 1, 1, 1, 0, 0, "mash_start"));
        st.push_back(mk(1, B_START, 0, 0, 1, 1, 1, 1, 1, 0, 0, "start_held"));
        st.push_back(mk(1, 4'b1110, 0, 0, 1, 1, 1, 1, 1, 0, 0, "overlap_ignored"));
        st.push_back(mk(1, 4'b0110, 0, 0, 1, 1, 1, 1, 1, 0, 0, "start_released_locked"));
        st.push_back(mk(1, 4'b0110, 0, 0, 1, 2, 2, 1, 1, 0, 0, "locked_tick"));
        st.push_back(mk(1, B_NONE,  0, 0, 1, 2, 2, 1, 1, 0, 0, "all_released"));
        st.push_back(mk(1, B_STOP,  0, 0, 1, 2, 2, 0, 1, 0, 0, "lone_stop"));
        st.push_back(mk(1, B_NONE,  0, 0, 1, 2, 2, 0, 1, 0, 0, "lone_stop_rel"));
        foreach (st[i]) begin
            drive(st[i]);
            wait_cyc(st[i].n);
            exp = sb_q.pop_front(); nm = sbn_q.pop_front(); got = observe();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s: got cnt=%0d disp=%0d run=%b up=%b lap=%b done=%b, expected cnt=%0d disp=%0d run=%b up=%b lap=%b done=%b",
                         nm, got.count, got.display, got.running, got.up, got.lapact, got.done,
                         exp.count, exp.display, exp.running, exp.up, exp.lapact, exp.done);
            end
        end
    endtask

    task automatic test_lap();
        step_t st[$];
        obs_t  got, exp;
        string nm;
        st.push_back(mk(1, B_CLEAR, 0, 0, 1,  0,  0,  0, 1, 0, 0, "lap_clear"));
        st.push_back(mk(1, B_NONE,  0, 0, 1,  0,  0,  0, 1, 0, 0, "lap_clear_rel"));
        st.push_back(mk(1, B_START, 0, 0, 1,  0,  0,  1, 1, 0, 0, "lap_start"));
        st.push_back(mk(1, B_NONE,  0, 0, 28, 7,  7,  1, 1, 0, 0, "count_7"));
        st.push_back(mk(1, B_LAP,   0, 0, 1,  7,  7,  1, 1, LAPEN, 0, "lap_freeze"));
        st.push_back(mk(1, B_NONE,  0, 0, 11, 10, LAPEN ? 8'd7 : 8'd10, 1, 1, LAPEN, 0, "lap_running"));
        st.push_back(mk(1, B_LAP,   0, 0, 1,  10, 10, 1, 1, LAPEN, 0, "relap"));
        st.push_back(mk(1, B_NONE,  0, 0, 3,  11, LAPEN ? 8'd10 : 8'd11, 1, 1, LAPEN, 0, "relap_running"));
        st.push_back(mk(1, B_STOP,  0, 0, 1,  11, 11, 0, 1, 0, 0, "lap_stop"));
        st.push_back(mk(1, B_LAP,   0, 0, 1,  11, 11, 0, 1, 0, 0, "lap_held_stopped"));
        st.push_back(mk(1, 4'b1001, 0, 0, 1,  11, 11, 0, 1, 0, 0, "start_blocked_by_lap"));
        st.push_back(mk(1, B_START, 0, 0, 1,  11, 11, 0, 1, 0, 0, "start_not_fresh"));
        st.push_back(mk(1, B_NONE,  0, 0, 1,  11, 11, 0, 1, 0, 0, "lap_all_rel"));
        foreach (st[i]) begin
            drive(st[i]);
            wait_cyc(st[i].n);
            exp = sb_q.pop_front(); nm = sbn_q.pop_front(); got = observe();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s: got cnt=%0d disp=%0d run=%b up=%b lap=%b done=%b, expected cnt=%0d disp=%0d run=%b up=%b lap=%b done=%b",
                         nm, got.count, got.display, got.running, got.up, got.lapact, got.done,
                         exp.count, exp.display, exp.running, exp.up, exp.lapact, exp.done);
            end
        end
    endtask

    task automatic test_reset_mid_count();
        step_t st[$];
        obs_t  got, exp;
        string nm;
        st.push_back(mk(1, B_CLEAR, 0, 0, 1,  0, 0, 0, 1, 0, 0, "rm_clear"));
        st.push_back(mk(1, B_NONE,  0, 0, 1,  0, 0, 0, 1, 0, 0, "rm_clear_rel"));
        st.push_back(mk(1, B_START, 1, 0, 1,  0, 0, 1, 0, 0, 0, "rm_start_down_zero"));
        st.push_back(mk(1, B_NONE,  1, 0, 4,  0, 0, 0, 0, 0, 1, "rm_zero_expire"));
        st.push_back(mk(1, B_STOP,  0, 0, 1,  0, 0, 0, 0, 0, 0, "rm_stop_from_expired"));
        st.push_back(mk(1, B_START, 0, 0, 1,  0, 0, 1, 1, 0, 0, "rm_start_up"));
        st.push_back(mk(1, B_NONE,  0, 0, 36, 9, 9, 1, 1, 0, 0, "rm_count_9"));
        st.push_back(mk(1, B_NONE,  0, 0, 2,  9, 9, 1, 1, 0, 0, "rm_hold_9"));
        st.push_back(mk(0, B_NONE,  0, 0, 1,  0, 0, 0, 1, 0, 0, "mid_reset"));
        st.push_back(mk(1, B_NONE,  0, 0, 5,  0, 0, 0, 1, 0, 0, "post_reset_idle"));
        foreach (st[i]) begin
            drive(st[i]);
            wait_cyc(st[i].n);
            exp = sb_q.pop_front(); nm = sbn_q.pop_front(); got = observe();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s: got cnt=%0d disp=%0d run=%b up=%b lap=%b done=%b, expected cnt=%0d disp=%0d run=%b up=%b lap=%b done=%b",
                         nm, got.count, got.display, got.running, got.up, got.lapact, got.done,
                         exp.count, exp.display, exp.running, exp.up, exp.lapact, exp.done);
            end
        end
    endtask

    initial begin
        resetN    = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        clear     = 1'b0;
        lap       = 1'b0;
        countDown = 1'b0;
        loadValue = '0;
        test_reset();
        test_count_up();
        test_countdown();
        test_wrap();
        test_mashing();
        test_lap();
        test_reset_mid_count();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
